// File: rtl/conv_block.sv
// conv_block: sequential 2-D convolution engine with an optional 2x2/stride-2
// max-pool stage, built around one multiply-accumulate per clock.
//
// On a start request the block convolves an internal FM_SIZE x FM_SIZE feature
// map with an internal KERNEL_SIZE x KERNEL_SIZE weight set. It then streams the
// results in raster order, one per o_en strobe.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          asynchronous, active-low reset
//   i_go           start request (level); one frame per assertion
//   o_en           one-cycle strobe marking a valid result
//   o_conv_result  48-bit signed result, held until the next result
module conv_block #(
    parameter int KERNEL_SIZE = 1,
    parameter int FM_SIZE     = 4,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int MAXPOOL     = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_go,
    output logic               o_en,
    output logic signed [47:0] o_conv_result
);
    localparam int OUT_SIZE = (FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE + 1;
    // Number of emitted results per edge: the pool stage drops an odd last row/column.
    localparam int OUT_DIM  = (MAXPOOL != 0) ? OUT_SIZE / 2 : OUT_SIZE;
    localparam int CW       = 16;
    localparam logic [CW-1:0] K_LAST = CW'(KERNEL_SIZE - 1);
    localparam logic [CW-1:0] O_LAST = CW'(OUT_DIM - 1);

    typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;
    state_t state_reg, state_next;

    // Kernel tap, pool sub-window (row si, column sj) and output position counters.
    logic [CW-1:0] kr_reg, kc_reg, pr_reg, pc_reg;
    logic          si_reg, sj_reg;
    logic signed [47:0] acc_reg, max_reg;

    logic mac_en, emit_en;
    logic last_tap, first_sub, last_sub, last_out;
    logic [CW-1:0] conv_row, conv_col;
    int   fm_row, fm_col;
    logic signed [17:0] fm_val, w_val;
    logic signed [35:0] prod;
    logic signed [47:0] acc_sum, max_next;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_go) state_next = CALC;
            CALC:    if (last_tap && last_sub) state_next = EMIT;
            EMIT:    state_next = last_out ? DONE : CALC;
            DONE:    if (!i_go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: control outputs ----------------
    always_comb begin
        mac_en  = 1'b0;
        emit_en = 1'b0;
        case (state_reg)
            CALC:    mac_en  = 1'b1;
            EMIT:    emit_en = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath (combinational) ----------------
    // Conv coordinate being accumulated: in pool mode the sub-window bits pick
    // one of the four conv outputs that feed the current pool window.
    assign conv_row = (MAXPOOL != 0) ? ((pr_reg << 1) | CW'(si_reg)) : pr_reg;
    assign conv_col = (MAXPOOL != 0) ? ((pc_reg << 1) | CW'(sj_reg)) : pc_reg;

    // Both ROMs hold pure functions of their address, so the lookup is written
    // as the address arithmetic itself; padded taps read as zero.
    always_comb begin
        fm_row = int'(conv_row) * STRIDE - PADDING + int'(kr_reg);
        fm_col = int'(conv_col) * STRIDE - PADDING + int'(kc_reg);
        fm_val = '0;
        if (fm_row >= 0 && fm_row < FM_SIZE && fm_col >= 0 && fm_col < FM_SIZE)
            fm_val = 18'(fm_row * FM_SIZE + fm_col + 1);
        w_val = 18'(int'(kr_reg) * KERNEL_SIZE + int'(kc_reg) + 1);
    end

    assign prod    = fm_val * w_val;
    assign acc_sum = acc_reg + {{12{prod[35]}}, prod};

    assign last_tap  = (kr_reg == K_LAST) && (kc_reg == K_LAST);
    assign first_sub = (MAXPOOL == 0) || (!si_reg && !sj_reg);
    assign last_sub  = (MAXPOOL == 0) || (si_reg && sj_reg);
    assign last_out  = (pr_reg == O_LAST) && (pc_reg == O_LAST);

    // Without pooling first_sub is always set, so max_next is simply the conv value.
    assign max_next = (first_sub || (acc_sum > max_reg)) ? acc_sum : max_reg;

    // ---------------- Datapath (sequential) ----------------
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_en          <= 1'b0;
            o_conv_result <= '0;
            acc_reg       <= '0;
            max_reg       <= '0;
            kr_reg        <= '0;
            kc_reg        <= '0;
            pr_reg        <= '0;
            pc_reg        <= '0;
            si_reg        <= 1'b0;
            sj_reg        <= 1'b0;
        end else begin
            o_en <= 1'b0;
            if (mac_en) begin
                if (last_tap) begin
                    // Conv value complete: fold into the pool max and restart the sum.
                    acc_reg <= '0;
                    max_reg <= max_next;
                    kr_reg  <= '0;
                    kc_reg  <= '0;
                    if (last_sub) begin
                        o_conv_result <= max_next;
                        o_en          <= 1'b1;
                    end
                    if (MAXPOOL != 0) begin
                        sj_reg <= ~sj_reg;
                        if (sj_reg) si_reg <= ~si_reg;
                    end
                end else begin
                    acc_reg <= acc_sum;
                    if (kc_reg == K_LAST) begin
                        kc_reg <= '0;
                        kr_reg <= kr_reg + 1'b1;
                    end else begin
                        kc_reg <= kc_reg + 1'b1;
                    end
                end
            end
            if (emit_en) begin
                acc_reg <= '0;
                // Position wraps to zero after the final result, ready for the next frame.
                if (pc_reg == O_LAST) begin
                    pc_reg <= '0;
                    pr_reg <= last_out ? '0 : pr_reg + 1'b1;
                end else begin
                    pc_reg <= pc_reg + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_block.sv
// tb_conv_block: self-checking bench for conv_block. Five instances cover the
// default pool configuration, plain convolution, padding, stride 2 and an
// odd-sized pool input; results are compared with a frame-level model.
module tb_conv_block;
    localparam int NCFG = 5;
    localparam int NVEC = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               go  [NCFG];
    logic               en  [NCFG];
    logic signed [47:0] res [NCFG];

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Configuration table mirrored by the instance parameters below.
    int cfg_k  [NCFG] = '{1, 3, 3, 2, 2};
    int cfg_fm [NCFG] = '{4, 4, 4, 4, 4};
    int cfg_p  [NCFG] = '{0, 0, 1, 0, 1};
    int cfg_s  [NCFG] = '{1, 1, 1, 2, 1};
    int cfg_mp [NCFG] = '{1, 0, 0, 0, 1};

    conv_block #(.KERNEL_SIZE(1), .FM_SIZE(4), .PADDING(0), .STRIDE(1), .MAXPOOL(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_go(go[0]), .o_en(en[0]), .o_conv_result(res[0]));
    conv_block #(.KERNEL_SIZE(3), .FM_SIZE(4), .PADDING(0), .STRIDE(1), .MAXPOOL(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_go(go[1]), .o_en(en[1]), .o_conv_result(res[1]));
    conv_block #(.KERNEL_SIZE(3), .FM_SIZE(4), .PADDING(1), .STRIDE(1), .MAXPOOL(0)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_go(go[2]), .o_en(en[2]), .o_conv_result(res[2]));
    conv_block #(.KERNEL_SIZE(2), .FM_SIZE(4), .PADDING(0), .STRIDE(2), .MAXPOOL(0)) dut_d (
        .i_clk(clk), .i_rst(rst), .i_go(go[3]), .o_en(en[3]), .o_conv_result(res[3]));
    conv_block #(.KERNEL_SIZE(2), .FM_SIZE(4), .PADDING(1), .STRIDE(1), .MAXPOOL(1)) dut_e (
        .i_clk(clk), .i_rst(rst), .i_go(go[4]), .o_en(en[4]), .o_conv_result(res[4]));

    // Captured strobes: value and the edge index at which o_en was seen high.
    longint cap_val [NCFG][$];
    int     cap_cyc [NCFG][$];

    always @(negedge clk) begin
        for (int i = 0; i < NCFG; i++) begin
            if (en[i]) begin
                cap_val[i].push_back(longint'(res[i]));
                cap_cyc[i].push_back(cycle);
                $display("[cfg %0d] strobe result=%0d edge=%0d", i, longint'(res[i]), cycle);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Frame-level reference: full conv map first, then optional pooling.
    longint model_q [$];

    function automatic void build_model(input int cfg);
        int k, fm, p, s, mp, os, rr, cc;
        logic signed [47:0] acc;
        longint conv [16][16];
        longint m;
        k  = cfg_k[cfg];
        fm = cfg_fm[cfg];
        p  = cfg_p[cfg];
        s  = cfg_s[cfg];
        mp = cfg_mp[cfg];
        os = (fm - k + 2 * p) / s + 1;
        model_q.delete();
        for (int r = 0; r < os; r++) begin
            for (int c = 0; c < os; c++) begin
                acc = '0;
                for (int kr = 0; kr < k; kr++) begin
                    for (int kc = 0; kc < k; kc++) begin
                        rr = r * s - p + kr;
                        cc = c * s - p + kc;
                        if (rr >= 0 && rr < fm && cc >= 0 && cc < fm)
                            acc = acc + 48'((rr * fm + cc + 1) * (kr * k + kc + 1));
                    end
                end
                conv[r][c] = longint'(acc);
            end
        end
        if (mp == 0) begin
            for (int r = 0; r < os; r++)
                for (int c = 0; c < os; c++)
                    model_q.push_back(conv[r][c]);
        end else begin
            for (int pr = 0; pr < os / 2; pr++) begin
                for (int pc = 0; pc < os / 2; pc++) begin
                    m = conv[2*pr][2*pc];
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 2; j++)
                            if (conv[2*pr+i][2*pc+j] > m) m = conv[2*pr+i][2*pc+j];
                    model_q.push_back(m);
                end
            end
        end
    endfunction

    function automatic int macs_per_result(input int cfg);
        return cfg_k[cfg] * cfg_k[cfg] * ((cfg_mp[cfg] != 0) ? 4 : 1);
    endfunction

    // Compare one captured frame against the model: count, values, strobe timing.
    task automatic check_frame(input int cfg, input int e0, input string tag);
        int n;
        build_model(cfg);
        n = macs_per_result(cfg);
        chk($sformatf("%s count", tag), cap_val[cfg].size(), model_q.size());
        for (int i = 0; i < model_q.size() && i < cap_val[cfg].size(); i++) begin
            chk($sformatf("%s value[%0d]", tag, i), cap_val[cfg][i], model_q[i]);
            chk($sformatf("%s edge[%0d]", tag, i), cap_cyc[cfg][i] - e0, n * (i + 1) + i);
        end
    endtask

    task automatic clear_cap(input int cfg);
        cap_val[cfg].delete();
        cap_cyc[cfg].delete();
    endtask

    typedef struct {
        int     cfg;
        int     idx;
        longint expv;
    } vec_t;
    vec_t vecs [NVEC];

    initial begin
        int e0;
        int seen;
        int cfg;
        int total;
        longint got;

        // Known results for the fixed configurations.
        vecs[0]  = '{0, 0, 6};
        vecs[1]  = '{0, 1, 8};
        vecs[2]  = '{0, 2, 14};
        vecs[3]  = '{0, 3, 16};
        vecs[4]  = '{1, 0, 348};
        vecs[5]  = '{1, 1, 393};
        vecs[6]  = '{1, 2, 528};
        vecs[7]  = '{1, 3, 573};
        vecs[8]  = '{2, 0, 111};
        vecs[9]  = '{3, 0, 44};
        vecs[10] = '{3, 1, 64};
        vecs[11] = '{3, 2, 124};
        vecs[12] = '{3, 3, 144};

        rst = 1'b0;
        for (int i = 0; i < NCFG; i++) go[i] = (i < 4) ? 1'b1 : 1'b0;

        // Reset held for 150 ns with i_go already high.
        repeat (3) @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            chk($sformatf("reset o_en cfg%0d", i), longint'(en[i]), 0);
            chk($sformatf("reset result cfg%0d", i), longint'(res[i]), 0);
        end
        repeat (12) @(negedge clk);
        rst = 1'b1;
        e0 = cycle + 1;

        // Long wait with i_go still high: exactly one frame per instance.
        repeat (250) @(negedge clk);
        for (int i = 0; i < 4; i++) check_frame(i, e0, $sformatf("cfg%0d first", i));

        for (int v = 0; v < NVEC; v++) begin
            got = (vecs[v].idx < cap_val[vecs[v].cfg].size()) ?
                  cap_val[vecs[v].cfg][vecs[v].idx] : -1;
            chk($sformatf("vector cfg%0d[%0d]", vecs[v].cfg, vecs[v].idx), got, vecs[v].expv);
        end
        for (int i = 1; i < 4; i++) go[i] = 1'b0;

        // Drop i_go for one cycle, raise again: identical second frame.
        @(negedge clk);
        go[0] = 1'b0;
        clear_cap(0);
        @(negedge clk);
        go[0] = 1'b1;
        e0 = cycle + 1;
        repeat (40) @(negedge clk);
        check_frame(0, e0, "default rerun");

        // Reset during the second strobe of a frame aborts immediately.
        @(negedge clk);
        go[0] = 1'b0;
        @(negedge clk);
        go[0] = 1'b1;
        seen = 0;
        for (int t = 0; t < 100 && seen < 2; t++) begin
            @(posedge clk);
            #1;
            if (en[0]) seen++;
        end
        chk("strobes before abort", seen, 2);
        chk("result before abort", longint'(res[0]), 8);
        #2 rst = 1'b0;
        #1;
        chk("abort o_en", longint'(en[0]), 0);
        chk("abort result", longint'(res[0]), 0);
        repeat (2) @(negedge clk);
        clear_cap(0);
        rst = 1'b1;
        e0 = cycle + 1;
        repeat (40) @(negedge clk);
        check_frame(0, e0, "after abort");
        go[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Random frames: random config, idle gap and i_go noise while busy.
        for (int f = 0; f < 6; f++) begin
            cfg = int'($urandom_range(0, NCFG - 1));
            build_model(cfg);
            total = model_q.size() * (macs_per_result(cfg) + 1);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            @(negedge clk);
            clear_cap(cfg);
            go[cfg] = 1'b1;
            e0 = cycle + 1;
            for (int t = 0; t < total - 5; t++) begin
                @(negedge clk);
                go[cfg] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            go[cfg] = 1'b0;
            repeat (20) @(negedge clk);
            check_frame(cfg, e0, $sformatf("random frame %0d cfg%0d", f, cfg));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_block.md
# conv_block

Sequential 2-D convolution engine with optional 2×2 max-pooling, built around a single DSP-style multiply-accumulate datapath. On a start request it convolves an internally stored FM_SIZE×FM_SIZE feature map with an internally stored KERNEL_SIZE×KERNEL_SIZE weight set. It streams results in raster order, one per output strobe. It is the compute core of the convolutional layer; downstream logic captures each strobed result into the output feature-map memory.

## Interface
- KERNEL_SIZE, 1, kernel edge length (≥1)
- FM_SIZE, 4, input feature-map edge length
- PADDING, 0, zero-padding on each border
- STRIDE, 1, convolution stride (≥1)
- MAXPOOL, 1, 1 = 2×2/stride-2 max-pool of conv outputs; 0 = raw conv outputs
- Derived OUT_SIZE = (FM_SIZE − KERNEL_SIZE + 2·PADDING)/STRIDE + 1 (integer division)
- i_clk  input  1  single clock, rising edge
- i_rst  input  1  asynchronous, active-low reset
- i_go  input  1  start request, level-sampled
- o_en  output  1  result strobe, one cycle per result
- o_conv_result  output  48 signed  result value

## Operation
- Feature-map storage is an internal ROM, 18-bit signed: fm[r][c] = r·FM_SIZE + c + 1.
- Weight storage is an internal ROM, 18-bit signed: w[kr][kc] = kr·KERNEL_SIZE + kc + 1.
- Conv value at (orow, ocol) = Σ fm[orow·STRIDE − PADDING + kr][ocol·STRIDE − PADDING + kc] · w[kr][kc].
  - Out-of-range fm coordinates read as 0.
  - Products are 36-bit, sign-extended to 48 bits. The accumulator is 48-bit two's complement and wraps on overflow.
- MAXPOOL=0: emits OUT_SIZE² results in raster order.
- MAXPOOL=1: emits (OUT_SIZE/2)² results in raster order of pool windows.
  - Each result is the signed maximum of conv values (2pr+i, 2pc+j), i,j ∈ {0,1}, computed in order (0,0),(0,1),(1,0),(1,1).
  - With odd OUT_SIZE, the last conv row and column are dropped.
- FSM states:
  - IDLE: waits for i_go=1, then goes to CALC.
  - CALC: one MAC per cycle, kernel in raster order. After the last MAC of an output, goes to EMIT.
  - EMIT: o_en=1 for one cycle. Goes back to CALC, or to DONE after the final result.
  - DONE: waits for i_go=0, then goes to IDLE.
- i_go changes during CALC/EMIT are ignored; a started frame always completes.
- Holding i_go high produces exactly one frame.

## Timing
- Reset values: o_en=0, o_conv_result=0, state IDLE, accumulator, max register and all counters 0. Reset mid-frame aborts immediately.
- Let N = KERNEL_SIZE² (MAXPOOL=0) or 4·KERNEL_SIZE² (MAXPOOL=1).
- Edge 0 samples i_go=1 in IDLE.
- Edges 1..N perform MACs. On edge N, o_conv_result is loaded with the final value and o_en goes to 1.
- o_en is high for exactly one cycle, then falls on the next edge.
- Result period is N+1 cycles.
- o_conv_result holds its value until the next result is loaded.
- During EMIT the accumulator is cleared. In max-pool mode, the first conv value of each window overwrites the max register instead of being compared.

## Test plan
- Defaults (K=1, FM=4, P=0, S=1, MAXPOOL=1), reset low 150 ns, then release with i_go=1 → exactly 4 strobes of values 6, 8, 14, 16.
  - First strobe at edge 4 after i_go is sampled; period 5 cycles.
  - No further strobes while i_go stays high.
- K=3, FM=4, P=0, S=1, MAXPOOL=0 → 348, 393, 528, 573; period 10 cycles.
- K=3, FM=4, P=1, S=1, MAXPOOL=0 → 16 results, first = 111 (padding zeros honoured).
- K=2, FM=4, P=0, S=2, MAXPOOL=0 → 44, 64, 124, 144.
- Assert i_rst=0 between the second and third strobe of the default run → o_en and o_conv_result go to 0 immediately.
  - After release with i_go=1, the full sequence 6, 8, 14, 16 restarts from the beginning.
- Default run, then drop i_go to 0 for one cycle and raise it again → a second identical frame of 4 results.
